accum_scheduler: RTL and testbench

//  Round-robin scheduler sharing one Accumulator (4x16b reduce) among NUM_REQ requesters.

---
 rtl/accum_scheduler.sv | 101 ++++++++++
 tb/tb_accum_scheduler.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/accum_scheduler.sv
// accum_scheduler: round-robin arbiter sharing one 4x16b Accumulator among NUM_REQ requesters.
// One job in flight; the result is returned tagged with the owner's id.
module accum_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [2*NUM_REQ-1:0]  req_mode,
  input  logic [64*NUM_REQ-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_err,
  output logic [63:0]           rsp_data,
  output logic [1:0]            acc_en,
  output logic                  acc_ready,
  output logic [15:0]           acc_in0,
  output logic [15:0]           acc_in1,
  output logic [15:0]           acc_in2,
  output logic [15:0]           acc_in3,
  input  logic [63:0]           acc_out,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] rr_ptr, win, idx;
  logic [ID_W:0] sum;
  logic found, accept, exec;
  logic [1:0] mode, win_mode, cnt, lat;
  logic [63:0] data;
  // Search from rr_ptr upward with wrap; first asserted valid wins.
  always_comb begin
    found = 1'b0;
    win = '0;
    sum = '0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
      idx = ID_W'(sum >= (ID_W+1)'(NUM_REQ) ? sum - (ID_W+1)'(NUM_REQ) : sum);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  assign accept    = rst_n && state == IDLE && found;
  assign req_ready = accept ? NUM_REQ'(1) << win : '0;
  assign win_mode  = req_mode[{win, 1'b0} +: 2];
  assign lat       = mode == 2'b00 ? 2'd1 : mode == 2'b01 ? 2'd2 : 2'd3;
  assign exec      = state == EXEC;
  assign rsp_valid = state == RESP;
  assign busy      = state != IDLE;
  assign acc_ready = exec;
  assign acc_en    = exec ? mode : 2'b00;
  assign acc_in0   = exec ? data[63:48] : '0;
  assign acc_in1   = exec ? data[47:32] : '0;
  assign acc_in2   = exec ? data[31:16] : '0;
  assign acc_in3   = exec ? data[15:0]  : '0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = win_mode == 2'b10 ? RESP : EXEC;
      EXEC:    if (cnt == lat) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_ptr   <= '0;
      cnt      <= '0;
      mode     <= '0;
      data     <= '0;
      rsp_id   <= '0;
      rsp_err  <= 1'b0;
      rsp_data <= '0;
    end else begin
      if (accept) begin
        mode     <= win_mode;
        data     <= req_data[{win, 6'b0} +: 64];
        rsp_id   <= win;
        rr_ptr   <= win == ID_W'(NUM_REQ-1) ? '0 : win + 1'b1;
        cnt      <= '0;
        rsp_err  <= win_mode == 2'b10;
        rsp_data <= '0;
      end
      if (exec) begin
        cnt <= cnt + 1'b1;
        if (cnt == lat) begin
          rsp_data <= acc_out;
          rsp_err  <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_accum_scheduler.sv
// tb_accum_scheduler: scoreboard bench for accum_scheduler with a behavioural Accumulator.
module tb_accum_scheduler;
  logic clk = 0, rst_n = 0, rsp_ready = 1, rsp_valid, rsp_err, acc_ready, busy;
  logic [3:0] req_valid = '0, req_ready;
  logic [7:0] req_mode = '0;
  logic [255:0] req_data = '0;
  logic [1:0] rsp_id, acc_en;
  logic [63:0] rsp_data, acc_out;
  logic [15:0] acc_in0, acc_in1, acc_in2, acc_in3;
  typedef struct {logic [1:0] id; logic err; logic [63:0] data; int lat;} exp_t;
  exp_t sb[$], e;
  int checks = 0, fails = 0, cyc = 0, acc_cyc = 0, accepts = 0;
  logic acc_seen = 0, prev_v = 0;

  accum_scheduler #(.NUM_REQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_data(rsp_data), .acc_en(acc_en),
    .acc_ready(acc_ready), .acc_in0(acc_in0), .acc_in1(acc_in1), .acc_in2(acc_in2),
    .acc_in3(acc_in3), .acc_out(acc_out), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] acc_model(logic [1:0] m, logic [15:0] a, b, c, d);
    return m == 2'b00 ? {a, b, c, d} : m == 2'b01 ? {32'b0, a + b, c + d} :
           m == 2'b11 ? {48'b0, a + b + c + d} : 64'h0;
  endfunction
  assign acc_out = acc_ready ? acc_model(acc_en, acc_in0, acc_in1, acc_in2, acc_in3) : 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (acc_ready) acc_seen = 1;
    if (|(req_ready & req_valid)) begin
      chk("ready_onehot", $countones(req_ready), 1);
      acc_cyc = cyc;
      acc_seen = 0;
      accepts++;
    end
    if (rsp_valid && !prev_v) begin
      if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        chk("latency", cyc - acc_cyc, sb[0].err ? 1 : sb[0].lat + 2);
        if (sb[0].err) chk("no_acc_ready", acc_seen, 0);
      end
    end
    if (rsp_valid && rsp_ready && sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_id", rsp_id, e.id);
      chk("rsp_err", rsp_err, e.err);
      chk("rsp_data", rsp_data, e.data);
    end
    prev_v = rsp_valid;
  end

  task automatic issue(int id, logic [1:0] m, logic [63:0] d);
    int n = 0;
    req_valid[id] = 1;
    req_mode[id*2 +: 2] = m;
    req_data[id*64 +: 64] = d;
    #1;
    while (!req_ready[id] && n < 50) begin @(posedge clk); #1; n++; end
    chk("grant_wait", n < 50, 1);
    @(posedge clk); #1;
    req_valid[id] = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain", n < 100, 1);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_acc", {acc_en, acc_ready, acc_in0, acc_in1, acc_in2, acc_in3}, 0);
    rst_n = 1;
    @(posedge clk); #1;
    sb.push_back('{0, 0, 64'd10, 3});
    issue(0, 2'b11, {16'd1, 16'd2, 16'd3, 16'd4});
    drain();
    sb.push_back('{1, 0, 64'h0000_0000_0000_000B, 2});
    issue(1, 2'b01, {16'hFFFF, 16'd1, 16'd5, 16'd6});
    drain();
    sb.push_back('{2, 1, 64'h0, 0});
    issue(2, 2'b10, 64'h1234_5678_9ABC_DEF0);
    drain();
    rsp_ready = 0;
    sb.push_back('{3, 0, 64'hAAAA_BBBB_CCCC_DDDD, 1});
    issue(3, 2'b00, 64'hAAAA_BBBB_CCCC_DDDD);
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("rsp_seen", n < 20, 1);
    req_valid[0] = 1;
    req_mode[1:0] = 2'b00;
    repeat (10) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, 64'hAAAA_BBBB_CCCC_DDDD);
      chk("hold_no_grant", req_ready, 0);
    end
    @(posedge clk); #1;
    req_valid[0] = 0;
    rsp_ready = 1;
    drain();
    // all four requesters contend; rr_ptr is back at 0 here
    req_mode = {2'b00, 2'b11, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) req_data[i*64 +: 64] = {16'(i + 1), 16'h0010, 16'h0100, 16'h1000};
    sb.push_back('{0, 0, 64'h0001_0010_0100_1000, 1});
    sb.push_back('{1, 0, 64'h0000_0000_0012_1100, 2});
    sb.push_back('{2, 0, 64'h0000_0000_0000_1113, 3});
    sb.push_back('{3, 0, 64'h0004_0010_0100_1000, 1});
    sb.push_back('{0, 0, 64'h0001_0010_0100_1000, 1});
    n = accepts + 5;
    req_valid = 4'hF;
    begin
      int t = 0;
      while (accepts < n && t < 200) begin @(posedge clk); #1; t++; end
      chk("rr_grants", t < 200, 1);
    end
    req_valid = '0;
    drain();
    issue(1, 2'b11, 64'h0001_0001_0001_0001);
    #2;
    req_valid[2] = 1;
    rst_n = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_outs", {rsp_valid, rsp_err, rsp_id, acc_en, acc_ready, req_ready}, 0);
    chk("mid_rst_acc_in", {acc_in0, acc_in1, acc_in2, acc_in3}, 0);
    chk("mid_rst_data", rsp_data, 0);
    @(posedge clk); #1;
    req_valid[2] = 0;
    rst_n = 1;
    repeat (8) begin
      @(negedge clk);
      chk("no_stale_rsp", rsp_valid, 0);
    end
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, fails);
    $fatal(1);
  end
endmodule
